// File: rtl/bp_pkg.sv
// Shared types for the BTB-based branch predictor: 2-bit counter encoding,
// per-entry state and the saturating counter update.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_e;

    // Width-independent entry state; tag and target live beside it in the table
    // because their widths follow the PC_WIDTH/ENTRIES parameters.
    typedef struct packed {
        logic    valid;
        bp_ctr_e ctr;
    } btb_entry_t;

    function automatic bp_ctr_e sat_update(input bp_ctr_e ctr, input logic taken);
        bp_ctr_e nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = bp_ctr_e'(ctr + 2'd1);
        end else begin
            if (ctr != SNT) nxt = bp_ctr_e'(ctr - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: two combinational read ports (Fetch lookup and
// Execute training) and one synchronous write port with synchronous reset clear.
module btb_table
    import bp_pkg::*;
#(
    parameter  int PC_WIDTH = 32,
    parameter  int ENTRIES  = 16,
    localparam int INDEX_W  = $clog2(ENTRIES),
    localparam int TAG_W    = PC_WIDTH - 2 - INDEX_W
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic [INDEX_W-1:0]  rd_idx_a_i,
    output btb_entry_t          rd_meta_a_o,
    output logic [TAG_W-1:0]    rd_tag_a_o,
    output logic [PC_WIDTH-1:0] rd_target_a_o,

    input  logic [INDEX_W-1:0]  rd_idx_b_i,
    output btb_entry_t          rd_meta_b_o,
    output logic [TAG_W-1:0]    rd_tag_b_o,
    output logic [PC_WIDTH-1:0] rd_target_b_o,

    input  logic                wr_en_i,
    input  logic [INDEX_W-1:0]  wr_idx_i,
    input  btb_entry_t          wr_meta_i,
    input  logic [TAG_W-1:0]    wr_tag_i,
    input  logic [PC_WIDTH-1:0] wr_target_i
);

    btb_entry_t          meta_q   [ENTRIES];
    btb_entry_t          meta_d   [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [TAG_W-1:0]    tag_d    [ENTRIES];
    logic [PC_WIDTH-1:0] target_q [ENTRIES];
    logic [PC_WIDTH-1:0] target_d [ENTRIES];

    // Reads see only registered state, so a same-cycle write is not bypassed.
    assign rd_meta_a_o   = meta_q[rd_idx_a_i];
    assign rd_tag_a_o    = tag_q[rd_idx_a_i];
    assign rd_target_a_o = target_q[rd_idx_a_i];
    assign rd_meta_b_o   = meta_q[rd_idx_b_i];
    assign rd_tag_b_o    = tag_q[rd_idx_b_i];
    assign rd_target_b_o = target_q[rd_idx_b_i];

    always_comb begin
        meta_d   = meta_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (wr_en_i) begin
            meta_d[wr_idx_i]   = wr_meta_i;
            tag_d[wr_idx_i]    = wr_tag_i;
            target_d[wr_idx_i] = wr_target_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                meta_q[i]   <= '{valid: 1'b0, ctr: WNT};
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else begin
            meta_q   <= meta_d;
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BTB lookup at Fetch, training and mispredict/recovery
// at Execute. Define BP_STATS_EN to build the branch/mispredict statistic counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter  int PC_WIDTH = 32,
    parameter  int ENTRIES  = 16,
    localparam int INDEX_W  = $clog2(ENTRIES),
    localparam int TAG_W    = PC_WIDTH - 2 - INDEX_W
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic [PC_WIDTH-1:0] PCF_i,
    output logic                PredTakenF_o,
    output logic [PC_WIDTH-1:0] PredTargetF_o,

    input  logic                UpdateE_i,
    input  logic                StallE_i,
    input  logic                IsJumpE_i,
    input  logic [PC_WIDTH-1:0] PCE_i,
    input  logic [PC_WIDTH-1:0] PCPlus4E_i,
    input  logic                TakenE_i,
    input  logic [PC_WIDTH-1:0] TargetE_i,
    input  logic                PredTakenE_i,
    input  logic [PC_WIDTH-1:0] PredTargetE_i,
    output logic                MispredictE_o,
    output logic [PC_WIDTH-1:0] RecoverPCE_o,

    output logic [31:0]         BranchCount_o,
    output logic [31:0]         MispredictCount_o
);

    logic [INDEX_W-1:0]  idx_f, idx_e;
    logic [TAG_W-1:0]    tag_f, tag_e;
    btb_entry_t          meta_f, meta_e;
    logic [TAG_W-1:0]    rd_tag_f, rd_tag_e;
    logic [PC_WIDTH-1:0] rd_target_f, rd_target_e;
    logic                hit_f, hit_e, accept_e;

    logic                wr_en;
    btb_entry_t          wr_meta;
    logic [TAG_W-1:0]    wr_tag;
    logic [PC_WIDTH-1:0] wr_target;

    // Instructions are word aligned; the low PC bits carry no information.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^{PCF_i[1:0], PCE_i[1:0]};

    assign idx_f = PCF_i[INDEX_W+1:2];
    assign tag_f = PCF_i[PC_WIDTH-1:INDEX_W+2];
    assign idx_e = PCE_i[INDEX_W+1:2];
    assign tag_e = PCE_i[PC_WIDTH-1:INDEX_W+2];

    btb_table #(
        .PC_WIDTH (PC_WIDTH),
        .ENTRIES  (ENTRIES)
    ) u_btb (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .rd_idx_a_i    (idx_f),
        .rd_meta_a_o   (meta_f),
        .rd_tag_a_o    (rd_tag_f),
        .rd_target_a_o (rd_target_f),
        .rd_idx_b_i    (idx_e),
        .rd_meta_b_o   (meta_e),
        .rd_tag_b_o    (rd_tag_e),
        .rd_target_b_o (rd_target_e),
        .wr_en_i       (wr_en),
        .wr_idx_i      (idx_e),
        .wr_meta_i     (wr_meta),
        .wr_tag_i      (wr_tag),
        .wr_target_i   (wr_target)
    );

    assign hit_f         = meta_f.valid && (rd_tag_f == tag_f);
    assign PredTakenF_o  = hit_f && (meta_f.ctr inside {WT, ST});
    assign PredTargetF_o = PredTakenF_o ? rd_target_f : '0;

    assign hit_e    = meta_e.valid && (rd_tag_e == tag_e);
    assign accept_e = UpdateE_i && !StallE_i;

    always_comb begin
        wr_en     = 1'b0;
        wr_meta   = meta_e;
        wr_tag    = tag_e;
        wr_target = rd_target_e;
        if (accept_e) begin
            if (hit_e) begin
                wr_en       = 1'b1;
                wr_meta.ctr = IsJumpE_i ? ST : sat_update(meta_e.ctr, TakenE_i);
                if (TakenE_i) wr_target = TargetE_i;
            end else if (TakenE_i) begin
                // Not-taken misses never allocate, so cold branches stay out of the table.
                wr_en     = 1'b1;
                wr_meta   = '{valid: 1'b1, ctr: (IsJumpE_i ? ST : WT)};
                wr_target = TargetE_i;
            end
        end
    end

    assign MispredictE_o = UpdateE_i &&
                           ((PredTakenE_i != TakenE_i) ||
                            (TakenE_i && (PredTargetE_i != TargetE_i)));
    assign RecoverPCE_o  = TakenE_i ? TargetE_i : PCPlus4E_i;

`ifdef BP_STATS_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (accept_e) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
            if (MispredictE_o) mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign BranchCount_o     = branch_cnt_q;
    assign MispredictCount_o = mispred_cnt_q;
`else
    assign BranchCount_o     = '0;
    assign MispredictCount_o = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: each op pushes its expected Execute and
// Fetch outputs, which are popped and compared on the following falling edge.
module tb_branch_predictor;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] PCF_i = '0;
    logic        PredTakenF_o;
    logic [31:0] PredTargetF_o;
    logic        UpdateE_i = 1'b0, StallE_i = 1'b0, IsJumpE_i = 1'b0;
    logic [31:0] PCE_i = '0, PCPlus4E_i = '0, TargetE_i = '0, PredTargetE_i = '0;
    logic        TakenE_i = 1'b0, PredTakenE_i = 1'b0;
    logic        MispredictE_o;
    logic [31:0] RecoverPCE_o, BranchCount_o, MispredictCount_o;

    branch_predictor #(.PC_WIDTH(32), .ENTRIES(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .PCF_i(PCF_i),
        .PredTakenF_o(PredTakenF_o), .PredTargetF_o(PredTargetF_o),
        .UpdateE_i(UpdateE_i), .StallE_i(StallE_i), .IsJumpE_i(IsJumpE_i),
        .PCE_i(PCE_i), .PCPlus4E_i(PCPlus4E_i), .TakenE_i(TakenE_i),
        .TargetE_i(TargetE_i), .PredTakenE_i(PredTakenE_i), .PredTargetE_i(PredTargetE_i),
        .MispredictE_o(MispredictE_o), .RecoverPCE_o(RecoverPCE_o),
        .BranchCount_o(BranchCount_o), .MispredictCount_o(MispredictCount_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        upd, stall, jump, taken, predt;
        logic [31:0] pce, tgt, predtgt, pcf;
        logic        e_mp;
        logic [31:0] e_rpc;
        logic        e_pt;
        logic [31:0] e_ptgt;
    } op_t;

    typedef struct {
        logic        mp;
        logic [31:0] rpc;
        logic        pt;
        logic [31:0] ptgt;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned exp_br = 0, exp_mpc = 0;

    task automatic drive_op(input op_t o);
        UpdateE_i     = o.upd;
        StallE_i      = o.stall;
        IsJumpE_i     = o.jump;
        TakenE_i      = o.taken;
        PredTakenE_i  = o.predt;
        PCE_i         = o.pce;
        PCPlus4E_i    = o.pce + 32'd4;
        TargetE_i     = o.tgt;
        PredTargetE_i = o.predtgt;
        PCF_i         = o.pcf;
        sb.push_back('{mp: o.e_mp, rpc: o.e_rpc, pt: o.e_pt, ptgt: o.e_ptgt});
        if (o.upd && !o.stall && !rst_i) begin
            exp_br++;
            if (o.e_mp) exp_mpc++;
        end
    endtask

    task automatic test_reset();
        op_t ops[$];
        exp_t e;
        logic [31:0] want_br, want_mp;
        // Update raised while reset is high, then a lookup of the same PC.
        ops.push_back('{1,0,0,1,0, 32'h100, 32'h80, 32'h0, 32'h100, 1, 32'h80, 0, 32'h0});
        ops.push_back('{0,0,0,0,0, 32'h0,   32'h0,  32'h0, 32'h100, 0, 32'h4,  0, 32'h0});
        repeat (2) @(posedge clk_i);
        #1;
        foreach (ops[i]) begin
            drive_op(ops[i]);
            @(negedge clk_i);
            e = sb.pop_front();
            checks += 4;
            if (MispredictE_o !== e.mp) begin errors++; $display("FAIL reset[%0d] mispredict got=%0b want=%0b", i, MispredictE_o, e.mp); end
            if (RecoverPCE_o !== e.rpc) begin errors++; $display("FAIL reset[%0d] recover_pc got=%h want=%h", i, RecoverPCE_o, e.rpc); end
            if (PredTakenF_o !== e.pt) begin errors++; $display("FAIL reset[%0d] pred_taken got=%0b want=%0b", i, PredTakenF_o, e.pt); end
            if (PredTargetF_o !== e.ptgt) begin errors++; $display("FAIL reset[%0d] pred_target got=%h want=%h", i, PredTargetF_o, e.ptgt); end
            @(posedge clk_i);
            #1;
            if (i == 0) rst_i = 1'b0;
        end
`ifdef BP_STATS_EN
        want_br = exp_br; want_mp = exp_mpc;
`else
        want_br = 0; want_mp = 0;
`endif
        checks += 2;
        if (BranchCount_o !== want_br) begin errors++; $display("FAIL reset branch_count got=%0d want=%0d", BranchCount_o, want_br); end
        if (MispredictCount_o !== want_mp) begin errors++; $display("FAIL reset mispredict_count got=%0d want=%0d", MispredictCount_o, want_mp); end
    endtask

    task automatic test_alloc();
        op_t ops[$];
        exp_t e;
        logic [31:0] want_br, want_mp;
        ops.push_back('{1,0,0,1,0, 32'h100, 32'h80, 32'h0, 32'h100, 1, 32'h80, 0, 32'h0});
        ops.push_back('{0,0,0,0,0, 32'h0,   32'h0,  32'h0, 32'h100, 0, 32'h4,  1, 32'h80});
        foreach (ops[i]) begin
            drive_op(ops[i]);
            @(negedge clk_i);
            e = sb.pop_front();
            checks += 4;
            if (MispredictE_o !== e.mp) begin errors++; $display("FAIL alloc[%0d] mispredict got=%0b want=%0b", i, MispredictE_o, e.mp); end
            if (RecoverPCE_o !== e.rpc) begin errors++; $display("FAIL alloc[%0d] recover_pc got=%h want=%h", i, RecoverPCE_o, e.rpc); end
            if (PredTakenF_o !== e.pt) begin errors++; $display("FAIL alloc[%0d] pred_taken got=%0b want=%0b", i, PredTakenF_o, e.pt); end
            if (PredTargetF_o !== e.ptgt) begin errors++; $display("FAIL alloc[%0d] pred_target got=%h want=%h", i, PredTargetF_o, e.ptgt); end
            @(posedge clk_i);
            #1;
        end
`ifdef BP_STATS_EN
        want_br = exp_br; want_mp = exp_mpc;
`else
        want_br = 0; want_mp = 0;
`endif
        checks += 2;
        if (BranchCount_o !== want_br) begin errors++; $display("FAIL alloc branch_count got=%0d want=%0d", BranchCount_o, want_br); end
        if (MispredictCount_o !== want_mp) begin errors++; $display("FAIL alloc mispredict_count got=%0d want=%0d", MispredictCount_o, want_mp); end
    endtask

    task automatic test_saturate();
        op_t ops[$];
        exp_t e;
        // 0x100 starts WT: WT->WNT->SNT->SNT, then two taken updates back to WT.
        ops.push_back('{1,0,0,0,1, 32'h100, 32'h0,  32'h80, 32'h100, 1, 32'h104, 1, 32'h80});
        ops.push_back('{1,0,0,0,0, 32'h100, 32'h0,  32'h0,  32'h100, 0, 32'h104, 0, 32'h0});
        ops.push_back('{1,0,0,0,0, 32'h100, 32'h0,  32'h0,  32'h100, 0, 32'h104, 0, 32'h0});
        ops.push_back('{1,0,0,1,0, 32'h100, 32'h80, 32'h0,  32'h100, 1, 32'h80,  0, 32'h0});
        ops.push_back('{0,0,0,0,0, 32'h0,   32'h0,  32'h0,  32'h100, 0, 32'h4,   0, 32'h0});
        ops.push_back('{1,0,0,1,0, 32'h100, 32'h80, 32'h0,  32'h100, 1, 32'h80,  0, 32'h0});
        ops.push_back('{0,0,0,0,0, 32'h0,   32'h0,  32'h0,  32'h100, 0, 32'h4,   1, 32'h80});
        foreach (ops[i]) begin
            drive_op(ops[i]);
            @(negedge clk_i);
            e = sb.pop_front();
            checks += 4;
            if (MispredictE_o !== e.mp) begin errors++; $display("FAIL saturate[%0d] mispredict got=%0b want=%0b", i, MispredictE_o, e.mp); end
            if (RecoverPCE_o !== e.rpc) begin errors++; $display("FAIL saturate[%0d] recover_pc got=%h want=%h", i, RecoverPCE_o, e.rpc); end
            if (PredTakenF_o !== e.pt) begin errors++; $display("FAIL saturate[%0d] pred_taken got=%0b want=%0b", i, PredTakenF_o, e.pt); end
            if (PredTargetF_o !== e.ptgt) begin errors++; $display("FAIL saturate[%0d] pred_target got=%h want=%h", i, PredTargetF_o, e.ptgt); end
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic test_alias();
        op_t ops[$];
        exp_t e;
        ops.push_back('{1,0,0,1,0, 32'h140, 32'h200, 32'h0, 32'h100, 1, 32'h200, 1, 32'h80});
        ops.push_back('{0,0,0,0,0, 32'h0,   32'h0,   32'h0, 32'h100, 0, 32'h4,   0, 32'h0});
        ops.push_back('{0,0,0,0,0, 32'h0,   32'h0,   32'h0, 32'h140, 0, 32'h4,   1, 32'h200});
        foreach (ops[i]) begin
            drive_op(ops[i]);
            @(negedge clk_i);
            e = sb.pop_front();
            checks += 4;
            if (MispredictE_o !== e.mp) begin errors++; $display("FAIL alias[%0d] mispredict got=%0b want=%0b", i, MispredictE_o, e.mp); end
            if (RecoverPCE_o !== e.rpc) begin errors++; $display("FAIL alias[%0d] recover_pc got=%h want=%h", i, RecoverPCE_o, e.rpc); end
            if (PredTakenF_o !== e.pt) begin errors++; $display("FAIL alias[%0d] pred_taken got=%0b want=%0b", i, PredTakenF_o, e.pt); end
            if (PredTargetF_o !== e.ptgt) begin errors++; $display("FAIL alias[%0d] pred_target got=%h want=%h", i, PredTargetF_o, e.ptgt); end
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic test_stall();
        op_t ops[$];
        exp_t e;
        logic [31:0] want_br, want_mp;
        // Not-taken update on 0x140 (WT) held stalled two cycles, then accepted once.
        ops.push_back('{1,1,0,0,1, 32'h140, 32'h0,   32'h200, 32'h140, 1, 32'h144, 1, 32'h200});
        ops.push_back('{1,1,0,0,1, 32'h140, 32'h0,   32'h200, 32'h140, 1, 32'h144, 1, 32'h200});
        ops.push_back('{1,0,0,0,1, 32'h140, 32'h0,   32'h200, 32'h140, 1, 32'h144, 1, 32'h200});
        ops.push_back('{0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h140, 0, 32'h4,   0, 32'h0});
        ops.push_back('{1,0,0,1,0, 32'h140, 32'h200, 32'h0,   32'h140, 1, 32'h200, 0, 32'h0});
        ops.push_back('{0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h140, 0, 32'h4,   1, 32'h200});
        foreach (ops[i]) begin
            drive_op(ops[i]);
            @(negedge clk_i);
            e = sb.pop_front();
            checks += 4;
            if (MispredictE_o !== e.mp) begin errors++; $display("FAIL stall[%0d] mispredict got=%0b want=%0b", i, MispredictE_o, e.mp); end
            if (RecoverPCE_o !== e.rpc) begin errors++; $display("FAIL stall[%0d] recover_pc got=%h want=%h", i, RecoverPCE_o, e.rpc); end
            if (PredTakenF_o !== e.pt) begin errors++; $display("FAIL stall[%0d] pred_taken got=%0b want=%0b", i, PredTakenF_o, e.pt); end
            if (PredTargetF_o !== e.ptgt) begin errors++; $display("FAIL stall[%0d] pred_target got=%h want=%h", i, PredTargetF_o, e.ptgt); end
            @(posedge clk_i);
            #1;
        end
`ifdef BP_STATS_EN
        want_br = exp_br; want_mp = exp_mpc;
`else
        want_br = 0; want_mp = 0;
`endif
        checks += 2;
        if (BranchCount_o !== want_br) begin errors++; $display("FAIL stall branch_count got=%0d want=%0d", BranchCount_o, want_br); end
        if (MispredictCount_o !== want_mp) begin errors++; $display("FAIL stall mispredict_count got=%0d want=%0d", MispredictCount_o, want_mp); end
    endtask

    task automatic test_jalr();
        op_t ops[$];
        exp_t e;
        ops.push_back('{1,0,1,1,1, 32'h20, 32'h304, 32'h300, 32'h20, 1, 32'h304, 0, 32'h0});
        ops.push_back('{0,0,0,0,0, 32'h0,  32'h0,   32'h0,   32'h20, 0, 32'h4,   1, 32'h304});
        ops.push_back('{1,0,0,0,1, 32'h20, 32'h0,   32'h304, 32'h20, 1, 32'h24,  1, 32'h304});
        ops.push_back('{1,0,0,0,1, 32'h20, 32'h0,   32'h304, 32'h20, 1, 32'h24,  1, 32'h304});
        ops.push_back('{1,0,1,1,0, 32'h20, 32'h308, 32'h0,   32'h20, 1, 32'h308, 0, 32'h0});
        ops.push_back('{1,0,0,0,1, 32'h20, 32'h0,   32'h308, 32'h20, 1, 32'h24,  1, 32'h308});
        ops.push_back('{1,0,0,1,1, 32'h20, 32'h308, 32'h308, 32'h20, 0, 32'h308, 1, 32'h308});
        ops.push_back('{0,0,0,0,0, 32'h0,  32'h0,   32'h0,   32'h20, 0, 32'h4,   1, 32'h308});
        foreach (ops[i]) begin
            drive_op(ops[i]);
            @(negedge clk_i);
            e = sb.pop_front();
            checks += 4;
            if (MispredictE_o !== e.mp) begin errors++; $display("FAIL jalr[%0d] mispredict got=%0b want=%0b", i, MispredictE_o, e.mp); end
            if (RecoverPCE_o !== e.rpc) begin errors++; $display("FAIL jalr[%0d] recover_pc got=%h want=%h", i, RecoverPCE_o, e.rpc); end
            if (PredTakenF_o !== e.pt) begin errors++; $display("FAIL jalr[%0d] pred_taken got=%0b want=%0b", i, PredTakenF_o, e.pt); end
            if (PredTargetF_o !== e.ptgt) begin errors++; $display("FAIL jalr[%0d] pred_target got=%h want=%h", i, PredTargetF_o, e.ptgt); end
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        op_t ops[$];
        exp_t e;
        logic [31:0] want_br, want_mp;
        ops.push_back('{1,0,0,1,0, 32'h64, 32'h10, 32'h0,  32'h64, 1, 32'h10, 0, 32'h0});
        ops.push_back('{1,0,0,1,1, 32'h64, 32'h14, 32'h10, 32'h64, 1, 32'h14, 1, 32'h10});
        ops.push_back('{1,0,0,0,1, 32'h64, 32'h0,  32'h14, 32'h64, 1, 32'h68, 1, 32'h14});
        ops.push_back('{0,0,0,0,0, 32'h0,  32'h0,  32'h0,  32'h64, 0, 32'h4,  1, 32'h14});
        ops.push_back('{1,0,0,0,0, 32'hA8, 32'h0,  32'h0,  32'hA8, 0, 32'hAC, 0, 32'h0});
        ops.push_back('{0,0,0,0,0, 32'h0,  32'h0,  32'h0,  32'hA8, 0, 32'h4,  0, 32'h0});
        ops.push_back('{0,0,0,1,1, 32'h64, 32'h50, 32'h0,  32'h64, 0, 32'h50, 1, 32'h14});
        ops.push_back('{0,0,0,0,0, 32'h0,  32'h0,  32'h0,  32'h64, 0, 32'h4,  1, 32'h14});
        foreach (ops[i]) begin
            drive_op(ops[i]);
            @(negedge clk_i);
            e = sb.pop_front();
            checks += 4;
            if (MispredictE_o !== e.mp) begin errors++; $display("FAIL b2b[%0d] mispredict got=%0b want=%0b", i, MispredictE_o, e.mp); end
            if (RecoverPCE_o !== e.rpc) begin errors++; $display("FAIL b2b[%0d] recover_pc got=%h want=%h", i, RecoverPCE_o, e.rpc); end
            if (PredTakenF_o !== e.pt) begin errors++; $display("FAIL b2b[%0d] pred_taken got=%0b want=%0b", i, PredTakenF_o, e.pt); end
            if (PredTargetF_o !== e.ptgt) begin errors++; $display("FAIL b2b[%0d] pred_target got=%h want=%h", i, PredTargetF_o, e.ptgt); end
            @(posedge clk_i);
            #1;
        end
`ifdef BP_STATS_EN
        want_br = exp_br; want_mp = exp_mpc;
`else
        want_br = 0; want_mp = 0;
`endif
        checks += 2;
        if (BranchCount_o !== want_br) begin errors++; $display("FAIL b2b branch_count got=%0d want=%0d", BranchCount_o, want_br); end
        if (MispredictCount_o !== want_mp) begin errors++; $display("FAIL b2b mispredict_count got=%0d want=%0d", MispredictCount_o, want_mp); end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_saturate();
        test_alias();
        test_stall();
        test_jalr();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
